// File: rtl/chs_pkg.sv
// Shared cool/heat system definitions: fan PWM frame geometry and decoder state type.
package chs_pkg;

  localparam int unsigned PWM_WIDTH  = 8;
  localparam int unsigned PWM_PERIOD = 2 ** PWM_WIDTH;

  typedef enum logic [0:0] {
    WAIT_RISE,
    MEASURE
  } pwm_dec_state_t;

endpackage

// File: rtl/pwm_edge_sampler.sv
// Registers the PWM line twice and flags a rising edge between the two samples.
module pwm_edge_sampler (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_pwm_data,
  output logic o_s,
  output logic o_s_prev,
  output logic o_rise
);

  logic r_s;
  logic r_s_prev;

  // Reset high so a line already high at reset release is not seen as a rise.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_s      <= 1'b1;
      r_s_prev <= 1'b1;
    end else begin
      r_s      <= i_pwm_data;
      r_s_prev <= r_s;
    end
  end

  assign o_s      = r_s;
  assign o_s_prev = r_s_prev;
  assign o_rise   = r_s & ~r_s_prev;

endmodule

// File: rtl/pwm_speed_decoder.sv
// Recovers the fan duty word from the PWM line once per frame and flags malformed
// or stuck-high streams.
module pwm_speed_decoder
  import chs_pkg::*;
#(
  parameter int unsigned WIDTH  = PWM_WIDTH,
  parameter int unsigned PERIOD = PWM_PERIOD
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_pwm_data,
  output logic [WIDTH-1:0] o_speed_out,
  output logic             o_speed_valid,
  output logic             o_fault,
  output logic             o_locked
);

  localparam logic [WIDTH:0] C_PERIOD  = (WIDTH + 1)'(PERIOD);
  localparam logic [WIDTH:0] C_PER_SAT = (WIDTH + 1)'(PERIOD + 1);
  localparam logic [WIDTH:0] C_ONE     = (WIDTH + 1)'(1);

  logic w_s;
  logic w_s_prev;
  logic w_rise;

  pwm_edge_sampler u_sampler (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_pwm_data (i_pwm_data),
    .o_s        (w_s),
    .o_s_prev   (w_s_prev),
    .o_rise     (w_rise)
  );

  pwm_dec_state_t   r_state, w_state_next;
  logic [WIDTH:0]   r_per_cnt, w_per_next;
  logic [WIDTH:0]   r_hi_cnt, w_hi_next;
  logic [WIDTH:0]   r_run_cnt, w_run_next;
  logic [WIDTH-1:0] r_speed, w_speed_next;
  logic             r_valid, w_valid_next;
  logic             r_fault, w_fault_next;
  logic             r_locked, w_locked_next;
  logic             w_run_hit;

  // Counters. A run threshold needs an unchanged sample, so it can never meet a rise.
  always_comb begin
    w_run_hit = (r_run_cnt == C_PERIOD) && (w_s == w_s_prev);
    if (w_rise) begin
      w_per_next = C_ONE;
      w_hi_next  = C_ONE;
    end else begin
      w_per_next = (r_per_cnt == C_PER_SAT) ? r_per_cnt : r_per_cnt + C_ONE;
      w_hi_next  = r_hi_cnt + {{WIDTH{1'b0}}, w_s};
    end
    if ((w_s != w_s_prev) || w_run_hit) begin
      w_run_next = C_ONE;
    end else begin
      w_run_next = r_run_cnt + C_ONE;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_speed_next  = r_speed;
    w_valid_next  = 1'b0;
    w_fault_next  = 1'b0;
    w_locked_next = r_locked;
    if (w_run_hit && !w_s) begin
      w_speed_next  = '0;
      w_valid_next  = 1'b1;
      w_locked_next = 1'b1;
      w_state_next  = WAIT_RISE;
    end else if (w_run_hit && w_s) begin
      w_fault_next  = 1'b1;
      w_locked_next = 1'b0;
      w_state_next  = WAIT_RISE;
    end else if (w_rise) begin
      case (r_state)
        WAIT_RISE: w_state_next = MEASURE;
        MEASURE: begin
          if (r_per_cnt == C_PERIOD) begin
            w_speed_next  = r_hi_cnt[WIDTH-1:0];
            w_valid_next  = 1'b1;
            w_locked_next = 1'b1;
          end else begin
            w_fault_next  = 1'b1;
            w_locked_next = 1'b0;
          end
        end
        default: w_state_next = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_state   <= WAIT_RISE;
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_run_cnt <= '0;
      r_speed   <= '0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_per_cnt <= w_per_next;
      r_hi_cnt  <= w_hi_next;
      r_run_cnt <= w_run_next;
      r_speed   <= w_speed_next;
      r_valid   <= w_valid_next;
      r_fault   <= w_fault_next;
      r_locked  <= w_locked_next;
    end
  end

  assign o_speed_out   = r_speed;
  assign o_speed_valid = r_valid;
  assign o_fault       = r_fault;
  assign o_locked      = r_locked;

endmodule

// File: tb/tb_pwm_speed_decoder.sv
// Randomized bench for pwm_speed_decoder against a sample-history reference model.
module tb_pwm_speed_decoder;

  localparam int P = 256;

  logic       clk  = 1'b0;
  logic       arst = 1'b1;
  logic       pwm  = 1'b0;
  logic [7:0] speed_out;
  logic       speed_valid;
  logic       fault;
  logic       locked;

  int total = 0;
  int bad   = 0;
  int tx_duty, tx_len, tx_phase;

  // Reference model: every sample since reset, frame bookkeeping by rise position.
  bit       m_samp[$];
  bit       m_meas;
  int       m_last_rise;
  bit       e_valid, e_fault, e_locked;
  bit [7:0] e_speed;

  pwm_speed_decoder dut (
    .i_clk         (clk),
    .i_arst        (arst),
    .i_pwm_data    (pwm),
    .o_speed_out   (speed_out),
    .o_speed_valid (speed_valid),
    .o_fault       (fault),
    .o_locked      (locked)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_samp      = {1'b1, 1'b1};
    m_meas      = 1'b0;
    m_last_rise = 0;
    e_valid     = 1'b0;
    e_fault     = 1'b0;
    e_locked    = 1'b0;
    e_speed     = 8'd0;
  endfunction

  // Outputs after this edge follow from the two newest samples; then p is sampled.
  function automatic void model_step(input bit p);
    int t   = m_samp.size() - 1;
    bit cur = m_samp[t];
    bit prv = m_samp[t-1];
    int len = 0;
    int ones = 0;
    e_valid = 1'b0;
    e_fault = 1'b0;
    for (int i = t - 1; i >= 1 && m_samp[i] == prv; i--) len++;
    if (cur == prv && len > 0 && (len % P) == 0) begin
      if (!cur) begin
        e_valid = 1'b1; e_speed = 8'd0; e_locked = 1'b1;
      end else begin
        e_fault = 1'b1; e_locked = 1'b0;
      end
      m_meas = 1'b0;
    end else if (cur && !prv) begin
      if (m_meas) begin
        if (t - m_last_rise == P) begin
          for (int i = m_last_rise; i < t; i++) ones += int'(m_samp[i]);
          e_valid = 1'b1; e_speed = 8'(ones); e_locked = 1'b1;
        end else begin
          e_fault = 1'b1; e_locked = 1'b0;
        end
      end
      m_meas      = 1'b1;
      m_last_rise = t;
    end
    m_samp.push_back(p);
  endfunction

  function automatic bit tx_next();
    bit b = (tx_phase < tx_duty);
    tx_phase = (tx_phase + 1) % tx_len;
    return b;
  endfunction

  task automatic tick(input bit p, input bit rst);
    @(negedge clk);
    pwm  = p;
    arst = rst;
    if (rst) model_reset();
    else model_step(p);
    @(posedge clk);
    #1;
  endtask

  task automatic tx_start(input int duty, input int len);
    tx_duty = duty; tx_len = len; tx_phase = 0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    total++;
    if ({speed_valid, fault, locked, speed_out} !== 11'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b f=%b l=%b spd=%0d want all 0",
               speed_valid, fault, locked, speed_out);
    end
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 1'b0);
      total++;
      if ({speed_valid, fault, locked, speed_out} !== {e_valid, e_fault, e_locked, e_speed}) begin
        bad++;
        $display("FAIL reset_quiet c=%0d got v=%b f=%b l=%b spd=%0d want v=%b f=%b l=%b spd=%0d",
                 c, speed_valid, fault, locked, speed_out, e_valid, e_fault, e_locked, e_speed);
      end
    end
  endtask

  task automatic test_speed_128();
    int nv = 0, nf = 0, first = -1;
    tick(1'b0, 1'b1);
    tx_start(128, P);
    for (int c = 0; c < 5 * P + 4; c++) begin
      tick(tx_next(), 1'b0);
      total++;
      if ({speed_valid, fault, locked, speed_out} !== {e_valid, e_fault, e_locked, e_speed}) begin
        bad++;
        $display("FAIL speed128 c=%0d got v=%b f=%b l=%b spd=%0d want v=%b f=%b l=%b spd=%0d",
                 c, speed_valid, fault, locked, speed_out, e_valid, e_fault, e_locked, e_speed);
      end
      if (speed_valid === 1'b1) begin nv++; if (first < 0) first = c; end
      if (fault === 1'b1) nf++;
    end
    total++;
    if (first != 2 * P + 1) begin
      bad++; $display("FAIL speed128_first_strobe got c=%0d want c=%0d", first, 2 * P + 1);
    end
    total++;
    if (nv != 4 || nf != 0) begin
      bad++; $display("FAIL speed128_counts got valid=%0d fault=%0d want 4 and 0", nv, nf);
    end
    total++;
    if (locked !== 1'b1 || speed_out !== 8'd128) begin
      bad++; $display("FAIL speed128_final got l=%b spd=%0d want 1 and 128", locked, speed_out);
    end
  endtask

  task automatic test_back_to_back();
    int nv = 0, nf = 0, last = -1, gap_bad = 0, duty = 1;
    tick(1'b0, 1'b1);
    tx_start(1, P);
    for (int c = 0; c < 10 * P + 2; c++) begin
      if (c % P == 0 && c < 10 * P) begin
        duty = (c < 3 * P) ? 1 : (c < 6 * P) ? 255 : int'($urandom_range(1, 255));
        tx_start(duty, P);
      end
      tick(tx_next(), 1'b0);
      total++;
      if ({speed_valid, fault, locked, speed_out} !== {e_valid, e_fault, e_locked, e_speed}) begin
        bad++;
        $display("FAIL back_to_back c=%0d got v=%b f=%b l=%b spd=%0d want v=%b f=%b l=%b spd=%0d",
                 c, speed_valid, fault, locked, speed_out, e_valid, e_fault, e_locked, e_speed);
      end
      if (speed_valid === 1'b1) begin
        if (last >= 0 && c - last != P) gap_bad++;
        last = c; nv++;
      end
      if (fault === 1'b1) nf++;
    end
    total++;
    if (nv != 9 || nf != 0 || gap_bad != 0) begin
      bad++;
      $display("FAIL back_to_back_counts got valid=%0d fault=%0d badgaps=%0d want 9 0 0",
               nv, nf, gap_bad);
    end
    total++;
    if (speed_out !== 8'(duty)) begin
      bad++; $display("FAIL back_to_back_final got spd=%0d want %0d", speed_out, duty);
    end
  endtask

  task automatic test_stuck_low();
    int nv = 0, nf = 0, first = -1;
    tick(1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      tick(1'b0, 1'b0);
      total++;
      if ({speed_valid, fault, locked, speed_out} !== {e_valid, e_fault, e_locked, e_speed}) begin
        bad++;
        $display("FAIL stuck_low c=%0d got v=%b f=%b l=%b spd=%0d want v=%b f=%b l=%b spd=%0d",
                 c, speed_valid, fault, locked, speed_out, e_valid, e_fault, e_locked, e_speed);
      end
      if (speed_valid === 1'b1) begin nv++; if (first < 0) first = c; end
      if (fault === 1'b1) nf++;
    end
    total++;
    if (nv != 2 || nf != 0 || first != P + 1 || locked !== 1'b1 || speed_out !== 8'd0) begin
      bad++;
      $display("FAIL stuck_low_summary got valid=%0d fault=%0d first=%0d l=%b spd=%0d want 2 0 %0d 1 0",
               nv, nf, first, locked, speed_out, P + 1);
    end
  endtask

  task automatic test_bad_frames();
    int nv = 0, nf = 0;
    int len = int'($urandom_range(100, 250));
    tick(1'b0, 1'b1);
    tx_start(len / 2, len);
    for (int c = 0; c < 6 * len; c++) begin
      tick(tx_next(), 1'b0);
      total++;
      if ({speed_valid, fault, locked, speed_out} !== {e_valid, e_fault, e_locked, e_speed}) begin
        bad++;
        $display("FAIL bad_frames len=%0d c=%0d got v=%b f=%b l=%b spd=%0d want v=%b f=%b l=%b spd=%0d",
                 len, c, speed_valid, fault, locked, speed_out, e_valid, e_fault, e_locked, e_speed);
      end
      if (speed_valid === 1'b1) nv++;
      if (fault === 1'b1) nf++;
    end
    total++;
    if (nv != 0 || nf != 4 || locked !== 1'b0) begin
      bad++;
      $display("FAIL bad_frames_summary got valid=%0d fault=%0d l=%b want 0 4 0", nv, nf, locked);
    end
  endtask

  task automatic test_stuck_high();
    int nf = 0;
    int duty = int'($urandom_range(1, 255));
    tick(1'b0, 1'b1);
    tx_start(duty, P);
    for (int c = 0; c < 3 * P + 600; c++) begin
      tick((c < 3 * P) ? tx_next() : 1'b1, 1'b0);
      total++;
      if ({speed_valid, fault, locked, speed_out} !== {e_valid, e_fault, e_locked, e_speed}) begin
        bad++;
        $display("FAIL stuck_high c=%0d got v=%b f=%b l=%b spd=%0d want v=%b f=%b l=%b spd=%0d",
                 c, speed_valid, fault, locked, speed_out, e_valid, e_fault, e_locked, e_speed);
      end
      if (fault === 1'b1) nf++;
    end
    total++;
    if (nf != 2 || locked !== 1'b0 || speed_out !== 8'(duty)) begin
      bad++;
      $display("FAIL stuck_high_summary got fault=%0d l=%b spd=%0d want 2 0 %0d",
               nf, locked, speed_out, duty);
    end
  endtask

  task automatic test_reset_mid();
    int nf = 0;
    bit got = 1'b0;
    int pre = 2 * P + int'($urandom_range(1, P - 1));
    tick(1'b0, 1'b1);
    tx_start(64, P);
    for (int c = 0; c < pre; c++) begin
      tick(tx_next(), 1'b0);
      total++;
      if ({speed_valid, fault, locked, speed_out} !== {e_valid, e_fault, e_locked, e_speed}) begin
        bad++;
        $display("FAIL reset_mid_pre c=%0d got v=%b f=%b l=%b spd=%0d want v=%b f=%b l=%b spd=%0d",
                 c, speed_valid, fault, locked, speed_out, e_valid, e_fault, e_locked, e_speed);
      end
    end
    tick(tx_next(), 1'b1);
    total++;
    if ({speed_valid, fault, locked, speed_out} !== 11'd0) begin
      bad++;
      $display("FAIL reset_mid_clear got v=%b f=%b l=%b spd=%0d want all 0",
               speed_valid, fault, locked, speed_out);
    end
    for (int c = 0; c < 2 * P + 4; c++) begin
      tick(tx_next(), 1'b0);
      total++;
      if ({speed_valid, fault, locked, speed_out} !== {e_valid, e_fault, e_locked, e_speed}) begin
        bad++;
        $display("FAIL reset_mid_post c=%0d got v=%b f=%b l=%b spd=%0d want v=%b f=%b l=%b spd=%0d",
                 c, speed_valid, fault, locked, speed_out, e_valid, e_fault, e_locked, e_speed);
      end
      if (speed_valid === 1'b1 && speed_out === 8'd64) got = 1'b1;
      if (fault === 1'b1) nf++;
    end
    total++;
    if (!got || nf != 0) begin
      bad++;
      $display("FAIL reset_mid_relock got seen64=%b fault=%0d want 1 and 0", got, nf);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_speed_128();
    test_back_to_back();
    test_stuck_low();
    test_bad_frames();
    test_stuck_high();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
